aes_word_loader: RTL and testbench

AES_WORD_LOADER -- requirements
Module: aes_word_loader

---
 rtl/aes_loader_pkg.sv | 32 +++
 rtl/aes_out_fifo.sv | 85 ++++++++
 rtl/aes_word_loader.sv | 168 ++++++++++++++++
 tb/tb_aes_word_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_loader_pkg : shared widths, FSM encoding and word-insert helper        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package aes_loader_pkg;

   localparam int WORD_W        = 32;
   localparam int BLK_W         = 128;
   localparam int WORDS_PER_BLK = 4;
   localparam int WCNT_W        = $clog2(WORDS_PER_BLK);

   typedef enum logic [1:0] {
      S_KEY    = 2'd0,
      S_TXT    = 2'd1,
      S_LAUNCH = 2'd2
   } loader_state_e;

   // Word 0 lands in the most-significant slot of the block.
   function automatic logic [BLK_W-1:0] insert_word(
      input logic [BLK_W-1:0]  blk,
      input logic [WCNT_W-1:0] idx,
      input logic [WORD_W-1:0] word
   );
      logic [BLK_W-1:0] res;
      res = blk;
      res[BLK_W-1 - int'(idx)*WORD_W -: WORD_W] = word;
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_out_fifo : first-word-fall-through ciphertext buffer with occupancy    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module aes_out_fifo
   import aes_loader_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = BLK_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full;
   logic             do_wr;
   logic             do_rd;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   // A pop frees the slot the same cycle, so a write at full is accepted alongside it.
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) begin
         wr_ptr_d = next_ptr(wr_ptr_q);
      end
      if (do_rd) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      if (do_wr && !do_rd) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_rd && !do_wr) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(wr_en && full && !do_rd));

endmodule
`default_nettype wire

// File: rtl/aes_word_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_word_loader : packs 32-bit key/plaintext words into AES-128 launches,  |
// | tracks core latency with a token pipe and buffers ciphertext. Rev 1.0      |
// +----------------------------------------------------------------------------+
module aes_word_loader
   import aes_loader_pkg::*;
#(
   parameter int AES_LATENCY = 21,
   parameter int OUT_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_key_reuse,
   output logic [BLK_W-1:0]  aes_state,
   output logic [BLK_W-1:0]  aes_key,
   input  logic [BLK_W-1:0]  aes_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BLK_W-1:0]  out_data,
   output logic              key_loaded
);

   localparam int CNT_W = $clog2(OUT_DEPTH+1);

   loader_state_e          state_q, state_d;
   logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
   logic [BLK_W-1:0]       blk_q, blk_d;
   logic [BLK_W-1:0]       key_asm_q, key_asm_d;
   logic [BLK_W-1:0]       key_q, key_d;
   logic                   key_loaded_q, key_loaded_d;
   logic                   in_ready_q, in_ready_d;
   logic [AES_LATENCY-1:0] vld_sr_q, vld_sr_d;
   logic [CNT_W-1:0]       inflight_q, inflight_d;

   logic                   xfer;
   logic                   launch;
   logic                   tail;
   logic                   fifo_empty;
   logic                   fifo_pop;
   logic [CNT_W-1:0]       fifo_count;
   logic [CNT_W:0]         credit;
   logic                   credit_ok;

   assign xfer       = in_valid && in_ready_q;
   assign in_ready   = in_ready_q;
   assign aes_state  = blk_q;
   assign aes_key    = key_q;
   assign key_loaded = key_loaded_q;

   // Blocks in the core plus blocks buffered may never exceed the FIFO depth.
   assign credit    = {1'b0, inflight_q} + {1'b0, fifo_count};
   assign credit_ok = (credit < (CNT_W+1)'(OUT_DEPTH));

   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      blk_d        = blk_q;
      key_asm_d    = key_asm_q;
      key_d        = key_q;
      key_loaded_d = key_loaded_q;
      launch       = 1'b0;
      unique case (state_q)
         S_KEY: begin
            if (xfer) begin
               if ((wcnt_q == '0) && in_key_reuse && key_loaded_q) begin
                  blk_d   = insert_word(blk_q, '0, in_data);
                  wcnt_d  = WCNT_W'(1);
                  state_d = S_TXT;
               end else begin
                  key_asm_d = insert_word(key_asm_q, wcnt_q, in_data);
                  wcnt_d    = wcnt_q + WCNT_W'(1);
                  if (wcnt_q == WCNT_W'(WORDS_PER_BLK-1)) begin
                     key_d        = key_asm_d;
                     key_loaded_d = 1'b1;
                     state_d      = S_TXT;
                  end
               end
            end
         end
         S_TXT: begin
            if (xfer) begin
               blk_d  = insert_word(blk_q, wcnt_q, in_data);
               wcnt_d = wcnt_q + WCNT_W'(1);
               if (wcnt_q == WCNT_W'(WORDS_PER_BLK-1)) begin
                  state_d = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            if (credit_ok) begin
               launch  = 1'b1;
               state_d = S_KEY;
            end
         end
         default: begin
            state_d = S_KEY;
            wcnt_d  = '0;
         end
      endcase
   end

   // Registered from the next state so in_ready is low throughout reset.
   assign in_ready_d = (state_d != S_LAUNCH);

   generate
      if (AES_LATENCY == 1) begin : g_sr_single
         assign vld_sr_d = launch;
      end else begin : g_sr_multi
         assign vld_sr_d = {vld_sr_q[AES_LATENCY-2:0], launch};
      end
   endgenerate

   assign tail = vld_sr_q[AES_LATENCY-1];

   always_comb begin
      inflight_d = inflight_q + CNT_W'(launch) - CNT_W'(tail);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_KEY;
         wcnt_q       <= '0;
         blk_q        <= '0;
         key_asm_q    <= '0;
         key_q        <= '0;
         key_loaded_q <= 1'b0;
         in_ready_q   <= 1'b0;
         vld_sr_q     <= '0;
         inflight_q   <= '0;
      end else begin
         state_q      <= state_d;
         wcnt_q       <= wcnt_d;
         blk_q        <= blk_d;
         key_asm_q    <= key_asm_d;
         key_q        <= key_d;
         key_loaded_q <= key_loaded_d;
         in_ready_q   <= in_ready_d;
         vld_sr_q     <= vld_sr_d;
         inflight_q   <= inflight_d;
      end
   end

   assign out_valid = !fifo_empty;
   assign fifo_pop  = out_valid && out_ready;

   aes_out_fifo #(
      .DEPTH (OUT_DEPTH),
      .WIDTH (BLK_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (tail),
      .wr_data (aes_out),
      .rd_en   (fifo_pop),
      .rd_data (out_data),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
      credit <= (CNT_W+1)'(OUT_DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_aes_word_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_word_loader : loader plus behavioural pipelined AES-128 core,       |
// | scoreboarded against an FIPS-197 reference. Rev 1.0                        |
// +----------------------------------------------------------------------------+
module tb_aes_word_loader;

   localparam int L = 21;
   localparam int D = 4;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_key_reuse = 1'b0;
   logic         out_ready = 1'b0;
   logic [31:0]  in_data = '0;
   logic         in_ready, out_valid, key_loaded;
   logic [127:0] aes_state, aes_key, aes_out, out_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_word_cyc = 0;
   int rx_count = 0;
   bit drv_done = 0;

   logic [7:0]   sbox [256];
   logic [127:0] core_pipe [L];
   logic [255:0] core_last = '1;
   logic [127:0] core_res = '0;
   logic [127:0] exp_q [$];
   logic [127:0] model_key = '0;
   bit           model_loaded = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_word_loader #(.AES_LATENCY(L), .OUT_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_key_reuse(in_key_reuse), .aes_state(aes_state),
      .aes_key(aes_key), .aes_out(aes_out), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .key_loaded(key_loaded)
   );

   // ---------------- AES-128 reference ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] b;
      for (int x = 0; x < 256; x++) begin
         b = 8'(x);
         inv = 8'h00;
         if (x != 0) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, b);
         end
         sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                   {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [127:0] st;
      logic [127:0] ns;
      logic [31:0]  t;
      logic [7:0]   rc, a0, a1, a2, a3;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      st = pt ^ {w[0], w[1], w[2], w[3]};
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) st[127-8*i -: 8] = sbox[st[127-8*i -: 8]];
         for (int i = 0; i < 16; i++)
            ns[127-8*i -: 8] = st[127-8*((((i/4) + (i%4)) % 4)*4 + (i%4)) -: 8];
         if (r != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = ns[127-32*c -: 8];
               a1 = ns[119-32*c -: 8];
               a2 = ns[111-32*c -: 8];
               a3 = ns[103-32*c -: 8];
               ns[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               ns[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               ns[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               ns[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         st = ns ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
      return st;
   endfunction

   // Pipelined core: output in cycle t is the cipher of the inputs seen in cycle t-L.
   always @(posedge clk) begin
      if ({aes_key, aes_state} !== core_last) begin
         core_last = {aes_key, aes_state};
         core_res  = aes_enc(aes_key, aes_state);
      end
      core_pipe[0] <= core_res;
      for (int i = 1; i < L; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign aes_out = core_pipe[L-1];

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_word(input logic [31:0] d, input logic reuse, input int gap);
      bit ok;
      int n;
      in_valid = 1'b0;
      repeat (gap) tick();
      in_valid = 1'b1;
      in_data = d;
      in_key_reuse = reuse;
      ok = 0;
      n = 0;
      while (!ok && n <= 2000) begin
         @(negedge clk);
         ok = in_ready;
         last_word_cyc = cyc;
         tick();
         n++;
      end
      check("word_accept_timeout", ok, 1);
      in_valid = 1'b0;
   endtask

   // Reference frame rule: reuse only honoured once a key is stored.
   task automatic send_frame(input logic [127:0] key, input logic [127:0] pt,
                             input logic reuse, input int max_gap);
      bit use_stored;
      use_stored = reuse && model_loaded;
      if (!use_stored) begin
         for (int i = 0; i < 4; i++)
            send_word(key[127-32*i -: 32], (i == 0) ? reuse : 1'($urandom),
                      $urandom_range(0, max_gap));
         model_key = key;
         model_loaded = 1;
      end
      for (int i = 0; i < 4; i++)
         send_word(pt[127-32*i -: 32], (use_stored && i == 0) ? 1'b1 : 1'($urandom),
                   $urandom_range(0, max_gap));
      exp_q.push_back(aes_enc(model_key, pt));
   endtask

   task automatic pulse_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_out_valid", out_valid, 0);
      check("rst_async_key_loaded", key_loaded, 0);
      check("rst_async_in_ready", in_ready, 0);
      exp_q.delete();
      model_loaded = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("in_ready_after_rst", in_ready, 1);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n;
      n = 0;
      while (!(drv_done && exp_q.size() == 0) && n < budget) begin
         tick();
         n++;
      end
      check(tag, exp_q.size(), 0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int n, hi, rx0;
      logic [127:0] exp;
      build_sbox();

      fork
         forever begin
            @(negedge clk);
            if (rst_n) begin
               if (exp_q.size() == 0) begin
                  check("idle_out_valid", out_valid, 0);
               end else if (out_valid && out_ready) begin
                  exp = exp_q.pop_front();
                  rx_count++;
                  check("out_data_order", out_data, exp);
               end
            end
         end
         begin
            #1_000_000;
            errors++;
            $display("FAIL watchdog: observed timeout expected completion");
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "watchdog");
         end
      join_none

      // reset state
      repeat (3) tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_key_loaded", key_loaded, 0);
      check("rst_aes_state", aes_state, 0);
      check("rst_aes_key", aes_key, 0);
      rst_n = 1'b1;
      tick();
      check("in_ready_first_edge", in_ready, 1);

      // FIPS-197 vector and latency
      drv_done = 1;
      out_ready = 1'b1;
      send_frame(FIPS_KEY, FIPS_PT, 1'b0, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 200);
      check("fips_latency", cyc - last_word_cyc, L + 2);
      check("fips_vector", out_data, FIPS_CT);
      check("fips_key_loaded", key_loaded, 1);
      tick();
      wait_drain("fips_drain", 100);

      // key reuse: 3 plaintext-only frames against the stored key
      rx0 = rx_count;
      for (int f = 0; f < 3; f++) send_frame(128'hdeadbeef, FIPS_PT, 1'b1, 0);
      wait_drain("reuse_drain", 200);
      check("reuse_count", rx_count - rx0, 3);
      check("reuse_state_held", aes_state, FIPS_PT);
      check("reuse_key_held", aes_key, FIPS_KEY);

      // reuse request before any key: full 8-word frame
      pulse_reset();
      out_ready = 1'b1;
      send_frame(FIPS_KEY, FIPS_PT, 1'b1, 0);
      check("noreuse_key_loaded", key_loaded, 1);
      check("noreuse_key_value", aes_key, FIPS_KEY);
      wait_drain("noreuse_drain", 200);

      // backpressure: 6 frames with the output stalled
      out_ready = 1'b0;
      rx0 = rx_count;
      drv_done = 0;
      fork
         begin
            for (int f = 0; f < 6; f++)
               send_frame('0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);
            drv_done = 1;
         end
      join_none
      n = 0;
      while (exp_q.size() < 5 && n < 400) begin
         tick();
         n++;
      end
      repeat (L + 10) tick();
      hi = 0;
      for (int i = 0; i < 30; i++) begin
         if (in_ready) hi++;
         tick();
      end
      check("bp_in_ready_low", hi, 0);
      check("bp_frames_accepted", exp_q.size(), 5);
      check("bp_out_valid", out_valid, 1);
      check("bp_nothing_popped", rx_count - rx0, 0);
      out_ready = 1'b1;
      wait_drain("bp_drain", 600);
      check("bp_rx_count", rx_count - rx0, 6);

      // reset with 2 blocks in flight and 1 buffered
      out_ready = 1'b0;
      send_frame('0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      send_frame('0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);
      send_frame('0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);
      pulse_reset();
      out_ready = 1'b1;
      hi = 0;
      for (int i = 0; i < 3 * L; i++) begin
         if (out_valid) hi++;
         tick();
      end
      check("post_rst_no_output", hi, 0);

      // random traffic with random output stalls
      drv_done = 0;
      fork
         while (!drv_done) begin
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
         end
      join_none
      for (int f = 0; f < 40; f++)
         send_frame({$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom},
                    1'($urandom), 2);
      drv_done = 1;
      out_ready = 1'b1;
      wait_drain("rand_drain", 800);
      check("rand_key_loaded", key_loaded, 1);
      check("rand_key_value", aes_key, model_key);

      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
